// File: rtl/time_disp_if.sv
// time_disp_if
//   Bundles the time-value inputs and the multiplexed 7-segment outputs of
//   the HH:MM:SS display scanner.
//   sec [5:0]  seconds (0..59 legal)          master -> slave
//   min [5:0]  minutes (0..59 legal)          master -> slave
//   hr  [4:0]  hours   (0..23 legal)          master -> slave
//   an  [5:0]  digit enables, active-low      slave  -> master
//   seg [6:0]  segments {g,f,e,d,c,b,a}, active-low
//   dp         decimal point, active-low      slave  -> master
`timescale 1ns/1ps
interface time_disp_if;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (output sec, min, hr, input an, seg, dp);
    modport slave  (input sec, min, hr, output an, seg, dp);
endinterface

// File: rtl/time_disp_scan.sv
// time_disp_scan
//   Drives a 6-digit multiplexed 7-segment display (HH MM SS) from the
//   sec/min/hr counter chain. A snapshot of the three fields is taken at the
//   start of every scan frame so a frame never mixes old and new values.
//   Digits are scanned one at a time, SCAN_DIV clocks per digit, idx0 = sec
//   ones ... idx5 = hr tens. Out-of-range fields show dashes on both digits.
//   Ports:
//     clk    clock, rising edge
//     rst_n  synchronous active-low reset
//     bus    time_disp_if.slave (sec/min/hr in, an/seg/dp out, all active-low out)
//   Parameters:
//     SCAN_DIV     clocks per digit slot (>= 2)
//     HR_BLANK_LZ  1: blank the hours-tens digit when it is zero
//   Optional feature macro: TIME_DISP_DP_BLINK_EN -- light dp on idx2/idx4
//     while snapshot seconds are even (separator blink); otherwise dp stays 1.
`timescale 1ns/1ps
module time_disp_scan #(
    parameter int SCAN_DIV    = 1000,
    parameter bit HR_BLANK_LZ = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    time_disp_if.slave bus
);
    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_DASH  = 7'h3F;
    localparam logic [6:0]    SEG_BLANK = 7'h7F;

    function automatic logic [3:0] bcd_tens(input logic [5:0] v);
        return 4'(v / 6'd10);
    endfunction

    function automatic logic [3:0] bcd_ones(input logic [5:0] v);
        return 4'(v % 6'd10);
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic          first;
    logic [5:0]    snap_sec;
    logic [5:0]    snap_min;
    logic [4:0]    snap_hr;

    logic          slot_end;
    logic          frame_end;
    logic [5:0]    cur_sec;
    logic [5:0]    cur_min;
    logic [4:0]    cur_hr;
    logic [5:0]    fld;
    logic          fld_ok;
    logic [3:0]    digit;
    logic [5:0]    an_p0;
    logic [6:0]    seg_p0;
    logic          dp_p0;

    // Stage p0: select the field for the current digit and decode it
    always_comb begin
        slot_end  = (pcnt == PCNT_LAST);
        frame_end = slot_end && (idx == 3'd5);

        // On the first active cycle the snapshot register is still being
        // loaded, so show the live inputs that are going into it.
        cur_sec = first ? bus.sec : snap_sec;
        cur_min = first ? bus.min : snap_min;
        cur_hr  = first ? bus.hr  : snap_hr;

        fld    = 6'd0;
        fld_ok = 1'b1;
        case (idx)
            3'd0, 3'd1: begin
                fld    = cur_sec;
                fld_ok = (cur_sec <= 6'd59);
            end
            3'd2, 3'd3: begin
                fld    = cur_min;
                fld_ok = (cur_min <= 6'd59);
            end
            default: begin
                fld    = {1'b0, cur_hr};
                fld_ok = (cur_hr <= 5'd23);
            end
        endcase

        digit = idx[0] ? bcd_tens(fld) : bcd_ones(fld);

        if (idx > 3'd5)
            seg_p0 = SEG_BLANK;
        else if (!fld_ok)
            seg_p0 = SEG_DASH;
        else if (HR_BLANK_LZ && (idx == 3'd5) && (digit == 4'd0))
            seg_p0 = SEG_BLANK;
        else
            seg_p0 = seg_decode(digit);

        an_p0 = ~(6'b1 << idx);

`ifdef TIME_DISP_DP_BLINK_EN
        dp_p0 = ~(((idx == 3'd2) || (idx == 3'd4)) && !cur_sec[0]);
`else
        dp_p0 = 1'b1;
`endif
    end

    // Stage p1: scan counters, snapshot, registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt     <= '0;
            idx      <= 3'd0;
            first    <= 1'b1;
            snap_sec <= 6'd0;
            snap_min <= 6'd0;
            snap_hr  <= 5'd0;
            bus.an   <= 6'h3F;
            bus.seg  <= SEG_BLANK;
            bus.dp   <= 1'b1;
        end else begin
            pcnt <= slot_end ? '0 : pcnt + PW'(1);
            if (slot_end)
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            if (frame_end || first) begin
                snap_sec <= bus.sec;
                snap_min <= bus.min;
                snap_hr  <= bus.hr;
            end
            first   <= 1'b0;
            bus.an  <= an_p0;
            bus.seg <= seg_p0;
            bus.dp  <= dp_p0;
        end
    end
endmodule
